// File: rtl/axicb_rd_pkg.sv
// Shared constants and address decoding for the crossbar read switches.
// AR layout is {len, id, addr}; R layout is {data, resp, id}, LSB first.
package axicb_rd_pkg;

  localparam int MAX_SLV     = 16;
  localparam int MAP_ADDR_W  = 64;
  localparam int TGT_W       = 5;
  localparam int LEN_W       = 8;
  localparam int RESP_W      = 2;

  localparam int ARCH_ADDR_LSB = 0;
  localparam int RCH_ID_LSB    = 0;

  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  function automatic int arch_id_lsb(input int addr_w);
    return ARCH_ADDR_LSB + addr_w;
  endfunction

  function automatic int arch_len_lsb(input int addr_w, input int id_w);
    return ARCH_ADDR_LSB + addr_w + id_w;
  endfunction

  // Map vectors use a fixed 64-bit stride; returns the lowest hit, or
  // slv_nb (the DECERR pseudo-target) when nothing matches.
  function automatic logic [TGT_W-1:0] addr_decode(
    input logic [MAP_ADDR_W-1:0]         addr,
    input logic [MAX_SLV*MAP_ADDR_W-1:0] start_vec,
    input logic [MAX_SLV*MAP_ADDR_W-1:0] end_vec,
    input logic [MAX_SLV-1:0]            routes,
    input int                            slv_nb
  );
    logic [TGT_W-1:0] tgt;
    tgt = TGT_W'(slv_nb);
    for (int i = MAX_SLV - 1; i >= 0; i--) begin
      if (i < slv_nb && routes[i] &&
          addr >= start_vec[i*MAP_ADDR_W +: MAP_ADDR_W] &&
          addr <= end_vec[i*MAP_ADDR_W +: MAP_ADDR_W])
        tgt = TGT_W'(i);
    end
    return tgt;
  endfunction

endpackage

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO; PASS_THRU=1 lets a push reach data_out while empty.
module axicb_scfifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int PASS_THRU  = 0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  input  logic              pull,
  output logic [DATA_W-1:0] data_out,
  output logic              empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                mem_empty;

  assign mem_empty = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // NOTE: storage is left unreset; the pointers alone define validity.
  always_ff @(posedge aclk) begin
    if (push && !full)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= data_in;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pull && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  generate
    if (PASS_THRU != 0) begin : g_pass
      assign data_out = mem_empty ? data_in : mem[rd_ptr[DEPTH_LOG2-1:0]];
      assign empty    = mem_empty && !push;
    end else begin : g_reg
      assign data_out = mem[rd_ptr[DEPTH_LOG2-1:0]];
      assign empty    = mem_empty;
    end
  endgenerate

endmodule

// File: rtl/axicb_slv_switch_rd_ord.sv
// Master-side read switch: routes AR to one slave, returns R in order by
// only switching targets once outstanding reads drain; answers misses with DECERR.
module axicb_slv_switch_rd_ord
  import axicb_rd_pkg::*;
#(
  parameter int AXI_ADDR_W    = 32,
  parameter int AXI_ID_W      = 8,
  parameter int AXI_SIGNALING = 1,
  parameter int SLV_NB        = 4,
  parameter logic [SLV_NB-1:0]            MST_ROUTES     = '1,
  parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_START_ADDR = '0,
  parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_END_ADDR   = '0,
  parameter int MAX_OSTDG     = 8,
  parameter int MR_DEPTH_LOG2 = 2,
  parameter int ARCH_W        = 48,
  parameter int RCH_W         = 42
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic                    i_arvalid,
  output logic                    i_arready,
  input  logic [ARCH_W-1:0]       i_arch,
  output logic                    i_rvalid,
  input  logic                    i_rready,
  output logic                    i_rlast,
  output logic [RCH_W-1:0]        i_rch,
  output logic [SLV_NB-1:0]       o_arvalid,
  input  logic [SLV_NB-1:0]       o_arready,
  output logic [ARCH_W-1:0]       o_arch,
  input  logic [SLV_NB-1:0]       o_rvalid,
  output logic [SLV_NB-1:0]       o_rready,
  input  logic [SLV_NB-1:0]       o_rlast,
  input  logic [SLV_NB*RCH_W-1:0] o_rch,
  output logic                    busy
);

  localparam int CNT_W   = $clog2(MAX_OSTDG) + 1;
  localparam int ID_LSB  = arch_id_lsb(AXI_ADDR_W);
  localparam int LEN_LSB = arch_len_lsb(AXI_ADDR_W, AXI_ID_W);
  localparam int RDATA_W = RCH_W - AXI_ID_W - RESP_W;
  localparam int MR_W    = LEN_W + AXI_ID_W;
  localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(SLV_NB);

  logic [MAX_SLV*MAP_ADDR_W-1:0] start_vec, end_vec;
  logic [TGT_W-1:0]    tgt, cur_tgt;
  logic [CNT_W-1:0]    ostdg_cnt;
  logic [LEN_W-1:0]    beat_cnt;
  logic                allow, slv_ready, tgt_err, ar_hs, r_last_hs;
  logic                dec_sel, dec_hs;
  logic [LEN_W-1:0]    ar_len, mr_len;
  logic [AXI_ID_W-1:0] mr_id;
  logic [MR_W-1:0]     mr_out;
  logic                mr_full, mr_empty;

  // Re-pack the address map onto the package's fixed decode stride.
  always_comb begin
    start_vec = '0;
    end_vec   = '0;
    for (int i = 0; i < SLV_NB; i++) begin
      start_vec[i*MAP_ADDR_W +: MAP_ADDR_W] = MAP_ADDR_W'(SLV_START_ADDR[i*AXI_ADDR_W +: AXI_ADDR_W]);
      end_vec[i*MAP_ADDR_W +: MAP_ADDR_W]   = MAP_ADDR_W'(SLV_END_ADDR[i*AXI_ADDR_W +: AXI_ADDR_W]);
    end
  end

  assign tgt = addr_decode(MAP_ADDR_W'(i_arch[ARCH_ADDR_LSB +: AXI_ADDR_W]),
                           start_vec, end_vec, MAX_SLV'(MST_ROUTES), SLV_NB);
  assign tgt_err = (tgt == ERR_TGT);
  assign ar_len  = (AXI_SIGNALING != 0) ? i_arch[LEN_LSB +: LEN_W] : '0;

  // A switch is also legal when the single outstanding read completes now.
  assign allow = (ostdg_cnt == '0) ||
                 ((tgt == cur_tgt) && (ostdg_cnt < CNT_W'(MAX_OSTDG))) ||
                 ((ostdg_cnt == CNT_W'(1)) && r_last_hs);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    o_arvalid = '0;
    slv_ready = 1'b0;
    for (int i = 0; i < SLV_NB; i++) begin
      if (tgt == TGT_W'(i)) begin
        o_arvalid[i] = i_arvalid && allow;
        slv_ready    = o_arready[i];
      end
    end
  end

  assign i_arready = allow && (tgt_err ? !mr_full : slv_ready);
  assign ar_hs     = i_arvalid && i_arready;
  assign o_arch    = i_arch;

  assign {mr_len, mr_id} = mr_out;
  assign dec_sel = (cur_tgt == ERR_TGT);

  always_comb begin
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    i_rch    = '0;
    o_rready = '0;
    if (dec_sel) begin
      i_rvalid = !mr_empty;
      i_rlast  = !mr_empty && (beat_cnt == mr_len);
      i_rch    = {{RDATA_W{1'b0}}, RESP_DECERR, mr_id};
    end else begin
      for (int i = 0; i < SLV_NB; i++) begin
        if (cur_tgt == TGT_W'(i)) begin
          i_rvalid    = o_rvalid[i];
          i_rlast     = o_rlast[i];
          i_rch       = o_rch[i*RCH_W +: RCH_W];
          o_rready[i] = i_rready;
        end
      end
    end
  end

  assign r_last_hs = i_rvalid && i_rready && i_rlast;
  assign dec_hs    = dec_sel && !mr_empty && i_rready;

  axicb_scfifo #(
    .DATA_W     (MR_W),
    .DEPTH_LOG2 (MR_DEPTH_LOG2),
    .PASS_THRU  (0)
  ) u_mr_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .srst     (srst),
    .push     (ar_hs && tgt_err),
    .data_in  ({ar_len, i_arch[ID_LSB +: AXI_ID_W]}),
    .full     (mr_full),
    .pull     (dec_hs && i_rlast),
    .data_out (mr_out),
    .empty    (mr_empty)
  );

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur_tgt   <= '0;
      ostdg_cnt <= '0;
      beat_cnt  <= '0;
    end else if (srst) begin
      cur_tgt   <= '0;
      ostdg_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      if (ar_hs)
        cur_tgt <= tgt;
      unique case ({ar_hs, r_last_hs})
        2'b10:   ostdg_cnt <= ostdg_cnt + CNT_W'(1);
        2'b01:   if (ostdg_cnt != '0) ostdg_cnt <= ostdg_cnt - CNT_W'(1);
        default: ;
      endcase
      if (dec_hs)
        beat_cnt <= i_rlast ? '0 : beat_cnt + 1'b1;
    end
  end

  assign busy = (ostdg_cnt != '0);

  a_no_underflow : assert property (@(posedge aclk) disable iff (!aresetn)
    r_last_hs |-> (ostdg_cnt != '0));

endmodule

// File: tb/tb_axicb_slv_switch_rd_ord.sv
// Directed bench: decode table plus hand-written multi-cycle sequences.
module tb_axicb_slv_switch_rd_ord;

  localparam int AW = 32;
  localparam int NS = 4;
  localparam logic [NS*AW-1:0] START_MAP = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
  localparam logic [NS*AW-1:0] END_MAP   = {32'h3FFF, 32'h2FFF, 32'h1FFF, 32'h0FFF};

  logic        aclk, aresetn, srst;
  logic        i_arvalid, i_arready, i_rvalid, i_rready, i_rlast, busy;
  logic [47:0] i_arch, o_arch;
  logic [41:0] i_rch;
  logic [3:0]  o_arvalid, o_arready, o_rvalid, o_rready, o_rlast;
  logic [167:0] o_rch;

  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, m_busy;
  logic [47:0] m_arch, m_oarch;
  logic [41:0] m_rch;
  logic [3:0]  m_oarvalid, m_orready;

  int errors, checks;

  axicb_slv_switch_rd_ord #(
    .AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_SIGNALING(1), .SLV_NB(4),
    .MST_ROUTES(4'b1111), .SLV_START_ADDR(START_MAP), .SLV_END_ADDR(END_MAP),
    .MAX_OSTDG(8), .MR_DEPTH_LOG2(2), .ARCH_W(48), .RCH_W(42)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch),
    .busy(busy)
  );

  axicb_slv_switch_rd_ord #(
    .AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_SIGNALING(0), .SLV_NB(4),
    .MST_ROUTES(4'b1110), .SLV_START_ADDR(START_MAP), .SLV_END_ADDR(END_MAP),
    .MAX_OSTDG(8), .MR_DEPTH_LOG2(2), .ARCH_W(48), .RCH_W(42)
  ) dut_lite (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_arvalid(m_arvalid), .i_arready(m_arready), .i_arch(m_arch),
    .i_rvalid(m_rvalid), .i_rready(m_rready), .i_rlast(m_rlast), .i_rch(m_rch),
    .o_arvalid(m_oarvalid), .o_arready(4'hF), .o_arch(m_oarch),
    .o_rvalid(4'h0), .o_rready(m_orready), .o_rlast(4'h0), .o_rch(168'h0),
    .busy(m_busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] mk_ar(input logic [31:0] addr, input logic [7:0] id,
                                        input logic [7:0] len);
    return {len, id, addr};
  endfunction

  task automatic set_slv(input int idx, input logic v, input logic l,
                         input logic [31:0] data, input logic [7:0] id);
    o_rvalid[idx] = v;
    o_rlast[idx]  = l;
    o_rch[idx*42 +: 42] = {data, 2'b00, id};
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  slv_rdy;
    logic [3:0]  exp_arvalid;
    logic        exp_arready;
  } dec_vec_t;

  dec_vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        ok, accepted;
    logic [3:0]  arv;
    logic [41:0] exp_rch;

    errors = 0; checks = 0;
    aresetn = 1'b0; srst = 1'b0;
    i_arvalid = 1'b0; i_arch = '0; i_rready = 1'b0;
    o_arready = '0; o_rvalid = '0; o_rlast = '0; o_rch = '0;
    m_arvalid = 1'b0; m_arch = '0; m_rready = 1'b0;

    vecs[0] = '{32'h0000_0000, 4'hF, 4'b0001, 1'b1};
    vecs[1] = '{32'h0000_0FFF, 4'hF, 4'b0001, 1'b1};
    vecs[2] = '{32'h0000_1000, 4'hF, 4'b0010, 1'b1};
    vecs[3] = '{32'h0000_2ABC, 4'hF, 4'b0100, 1'b1};
    vecs[4] = '{32'h0000_3FFF, 4'hF, 4'b1000, 1'b1};
    vecs[5] = '{32'h0000_4000, 4'hF, 4'b0000, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 4'hF, 4'b0000, 1'b1};
    vecs[7] = '{32'h0000_1004, 4'b1101, 4'b0010, 1'b0};
    vecs[8] = '{32'h0000_3000, 4'b0000, 4'b1000, 1'b0};

    // Reset state
    repeat (3) @(negedge aclk);
    #1;
    check("rst_rvalid", 64'(i_rvalid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_arvalid", 64'(o_arvalid), 64'(0));
    check("rst_lite_busy", 64'(m_busy), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    check("post_rst_rvalid", 64'(i_rvalid), 64'(0));
    check("post_rst_rready", 64'(o_rready), 64'(0));

    // Decode table, applied while idle and withdrawn before the clock edge
    for (int k = 0; k < 9; k++) begin
      @(negedge aclk);
      o_arready = vecs[k].slv_rdy;
      i_arch    = mk_ar(vecs[k].addr, 8'h00, 8'h00);
      i_arvalid = 1'b1;
      #1;
      check($sformatf("dec%0d_arvalid", k), 64'(o_arvalid), 64'(vecs[k].exp_arvalid));
      check($sformatf("dec%0d_arready", k), 64'(i_arready), 64'(vecs[k].exp_arready));
      check($sformatf("dec%0d_arch", k), 64'(o_arch), 64'(mk_ar(vecs[k].addr, 8'h00, 8'h00)));
      #1 i_arvalid = 1'b0;
    end

    // Single read to slave 2, len=3
    @(negedge aclk);
    o_arready = 4'hF;
    i_arch    = mk_ar(32'h0000_2010, 8'h11, 8'd3);
    i_arvalid = 1'b1;
    #1;
    check("t1_arvalid", 64'(o_arvalid), 64'(4'b0100));
    check("t1_arready", 64'(i_arready), 64'(1));
    @(negedge aclk);
    i_arvalid = 1'b0;
    #1 check("t1_busy_on", 64'(busy), 64'(1));
    i_rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge aclk);
      set_slv(2, 1'b1, (b == 3), 32'h100 + 32'(b), 8'h11);
      #1;
      check($sformatf("t1_b%0d_rvalid", b), 64'(i_rvalid), 64'(1));
      check($sformatf("t1_b%0d_rlast", b), 64'(i_rlast), 64'(b == 3));
      check($sformatf("t1_b%0d_rch", b), 64'(i_rch), 64'({32'h100 + 32'(b), 2'b00, 8'h11}));
      check($sformatf("t1_b%0d_rready", b), 64'(o_rready), 64'(4'b0100));
    end
    @(negedge aclk);
    o_rvalid = '0; o_rlast = '0; i_rready = 1'b0;
    #1 check("t1_busy_off", 64'(busy), 64'(0));

    // Two reads to slave 0, then a read to slave 1 that must wait
    @(negedge aclk);
    i_arch = mk_ar(32'h0000_0010, 8'h01, 8'd0);
    i_arvalid = 1'b1;
    #1 check("t2_ar1_rdy", 64'(i_arready), 64'(1));
    @(negedge aclk);
    i_arch = mk_ar(32'h0000_0020, 8'h02, 8'd0);
    #1 check("t2_ar2_rdy", 64'(i_arready), 64'(1));
    @(negedge aclk);
    i_arch = mk_ar(32'h0000_1010, 8'h03, 8'd0);
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge aclk);
      #1 if (i_arready || (o_arvalid != 4'b0000)) ok = 1'b0;
    end
    check("t2_ar3_stalled", 64'(ok), 64'(1));
    @(negedge aclk);
    i_rready = 1'b1;
    set_slv(0, 1'b1, 1'b1, 32'hA1, 8'h01);
    #1;
    check("t2_r1_rch", 64'(i_rch), 64'({32'hA1, 2'b00, 8'h01}));
    check("t2_ar3_stall_r1", 64'(i_arready), 64'(0));
    @(negedge aclk);
    set_slv(0, 1'b1, 1'b1, 32'hA2, 8'h02);
    arv = 4'b0000;
    #1;
    check("t2_r2_rch", 64'(i_rch), 64'({32'hA2, 2'b00, 8'h02}));
    accepted = i_arready;
    if (accepted) arv = o_arvalid;
    @(negedge aclk);
    o_rvalid = '0; o_rlast = '0;
    if (accepted) i_arvalid = 1'b0;
    else begin
      #1 accepted = i_arready;
      if (accepted) arv = o_arvalid;
    end
    check("t2_ar3_accepted", 64'(accepted), 64'(1));
    check("t2_ar3_arvalid", 64'(arv), 64'(4'b0010));
    if (i_arvalid) begin
      @(negedge aclk);
      i_arvalid = 1'b0;
    end
    @(negedge aclk);
    set_slv(0, 1'b1, 1'b1, 32'hDEAD, 8'hEE);
    set_slv(1, 1'b1, 1'b1, 32'hB3, 8'h03);
    #1;
    check("t2_r3_rch", 64'(i_rch), 64'({32'hB3, 2'b00, 8'h03}));
    check("t2_r3_rready", 64'(o_rready), 64'(4'b0010));
    @(negedge aclk);
    o_rvalid = '0; o_rlast = '0; i_rready = 1'b0;
    #1 check("t2_busy_off", 64'(busy), 64'(0));

    // Unmapped address, id=0x5A, len=2 -> three DECERR beats
    @(negedge aclk);
    i_arch = mk_ar(32'h0000_8000, 8'h5A, 8'd2);
    i_arvalid = 1'b1;
    #1;
    check("t3_arvalid", 64'(o_arvalid), 64'(0));
    check("t3_arready", 64'(i_arready), 64'(1));
    exp_rch = {32'h0, 2'b11, 8'h5A};
    for (int b = 0; b < 3; b++) begin
      @(negedge aclk);
      i_arvalid = 1'b0;
      i_rready = 1'b1;
      #1;
      check($sformatf("t3_b%0d_rvalid", b), 64'(i_rvalid), 64'(1));
      check($sformatf("t3_b%0d_rlast", b), 64'(i_rlast), 64'(b == 2));
      check($sformatf("t3_b%0d_rch", b), 64'(i_rch), 64'(exp_rch));
    end
    @(negedge aclk);
    i_rready = 1'b0;
    #1;
    check("t3_rvalid_off", 64'(i_rvalid), 64'(0));
    check("t3_busy_off", 64'(busy), 64'(0));

    // DECERR beat held stable under back-pressure
    @(negedge aclk);
    i_arch = mk_ar(32'h0001_0000, 8'h33, 8'd1);
    i_arvalid = 1'b1;
    @(negedge aclk);
    i_arvalid = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1 if (!i_rvalid || i_rlast || (i_rch !== {32'h0, 2'b11, 8'h33})) ok = 1'b0;
      @(negedge aclk);
    end
    check("t3b_decerr_stable", 64'(ok), 64'(1));
    i_rready = 1'b1;
    #1 check("t3b_b0_rlast", 64'(i_rlast), 64'(0));
    @(negedge aclk);
    #1 check("t3b_b1_rlast", 64'(i_rlast), 64'(1));
    @(negedge aclk);
    i_rready = 1'b0;
    #1 check("t3b_busy_off", 64'(busy), 64'(0));

    // Masked route and AXI4-lite: slave 0 address answers with one DECERR beat
    @(negedge aclk);
    m_arch = mk_ar(32'h0000_1000, 8'h00, 8'd0);
    m_arvalid = 1'b1;
    #1 check("t4_slv1_route", 64'(m_oarvalid), 64'(4'b0010));
    #1 m_arvalid = 1'b0;
    @(negedge aclk);
    m_arch = mk_ar(32'h0000_0100, 8'h77, 8'd5);
    m_arvalid = 1'b1;
    #1;
    check("t4_arvalid", 64'(m_oarvalid), 64'(0));
    check("t4_arready", 64'(m_arready), 64'(1));
    @(negedge aclk);
    m_arvalid = 1'b0;
    m_rready = 1'b1;
    #1;
    check("t4_rvalid", 64'(m_rvalid), 64'(1));
    check("t4_rlast", 64'(m_rlast), 64'(1));
    check("t4_rch", 64'(m_rch), 64'({32'h0, 2'b11, 8'h77}));
    @(negedge aclk);
    m_rready = 1'b0;
    #1;
    check("t4_rvalid_off", 64'(m_rvalid), 64'(0));
    check("t4_busy_off", 64'(m_busy), 64'(0));

    // Outstanding limit: eight reads accepted, ninth stalled
    @(negedge aclk);
    o_arready = 4'b1000;
    i_arch = mk_ar(32'h0000_3100, 8'h21, 8'd0);
    i_arvalid = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge aclk);
      #1 if (!i_arready || (o_arvalid != 4'b1000)) ok = 1'b0;
    end
    check("t5_eight_accepted", 64'(ok), 64'(1));
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      #1 if (i_arready || (o_arvalid != 4'b0000)) ok = 1'b0;
    end
    check("t5_ninth_stalled", 64'(ok), 64'(1));
    @(negedge aclk);
    i_arvalid = 1'b0;
    set_slv(3, 1'b1, 1'b1, 32'hC0, 8'h21);
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1 if (!i_rvalid || (o_rready != 4'b0000) || (i_rch !== {32'hC0, 2'b00, 8'h21})) ok = 1'b0;
      @(negedge aclk);
    end
    check("t5_slave_stable", 64'(ok), 64'(1));
    check("t5_busy_held", 64'(busy), 64'(1));
    i_rready = 1'b1;
    repeat (8) @(posedge aclk);
    @(negedge aclk);
    o_rvalid = '0; o_rlast = '0; i_rready = 1'b0;
    #1 check("t5_busy_off", 64'(busy), 64'(0));

    // Asynchronous reset in the middle of a DECERR burst
    @(negedge aclk);
    i_arch = mk_ar(32'h0000_9000, 8'h44, 8'd3);
    i_arvalid = 1'b1;
    @(negedge aclk);
    i_arvalid = 1'b0;
    i_rready = 1'b1;
    #1 check("t6_beat0_rvalid", 64'(i_rvalid), 64'(1));
    @(negedge aclk);
    i_rready = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_rvalid", 64'(i_rvalid), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    i_rready = 1'b1;
    #1 check("t6_fifo_empty", 64'(i_rvalid), 64'(0));
    @(negedge aclk);
    i_rready = 1'b0;
    #1 check("t6_busy_after", 64'(busy), 64'(0));

    // Synchronous reset clears a pending DECERR on the following edge
    @(negedge aclk);
    i_arch = mk_ar(32'h0000_A000, 8'h66, 8'd0);
    i_arvalid = 1'b1;
    @(negedge aclk);
    i_arvalid = 1'b0;
    srst = 1'b1;
    #1 check("t7_before_srst", 64'(i_rvalid), 64'(1));
    @(negedge aclk);
    srst = 1'b0;
    #1;
    check("t7_srst_rvalid", 64'(i_rvalid), 64'(0));
    check("t7_srst_busy", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
